// File: rtl/shift_arbiter_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | shift_arbiter_if : request/shifter/response bundle for shift_arbiter |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface shift_arbiter_if;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [31:0] req_data0;
  logic [31:0] req_data1;
  logic [4:0]  req_shamt0;
  logic [4:0]  req_shamt1;
  logic [3:0]  req_op0;
  logic [3:0]  req_op1;
  logic [31:0] sh_inp1;
  logic [4:0]  sh_inp2;
  logic [3:0]  sh_alusel;
  logic [31:0] sh_out;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_illegal;

  // Arbiter side
  modport slave (
    input  req_valid, req_data0, req_data1, req_shamt0, req_shamt1,
           req_op0, req_op1, sh_out, rsp_ready,
    output req_ready, sh_inp1, sh_inp2, sh_alusel, rsp_valid, rsp_data,
           rsp_illegal
  );

  // Requester / shifter side
  modport master (
    output req_valid, req_data0, req_data1, req_shamt0, req_shamt1,
           req_op0, req_op1, sh_out, rsp_ready,
    input  req_ready, sh_inp1, sh_inp2, sh_alusel, rsp_valid, rsp_data,
           rsp_illegal
  );
endinterface
`default_nettype wire

// File: rtl/shift_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | shift_arbiter : shares one barrel shifter between two requesters.  |
// | Round-robin; SHIFT_ARB_FIXED_PRIO_EN gives requester 0 priority.   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module shift_arbiter #(
  parameter logic [3:0] OP_SLL = 4'd2,
  parameter logic [3:0] OP_SRL = 4'd6,
  parameter logic [3:0] OP_SRA = 4'd7
) (
  input  logic              clk,
  input  logic              rst_n,
  shift_arbiter_if.slave    bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RESP  = 2'd2
  } state_t;

  state_t      state_q;
  logic        win_q;
  logic        illegal_q;
  logic [31:0] sh_inp1_q;
  logic [4:0]  sh_inp2_q;
  logic [3:0]  sh_alusel_q;
  logic [1:0]  rsp_valid_q;
  logic [31:0] rsp_data_q;
  logic        rsp_illegal_q;

  logic        win_d;
  logic [1:0]  gnt_d;
  logic [31:0] data_d;
  logic [4:0]  shamt_d;
  logic [3:0]  op_d;
  logic        legal_d;

`ifndef SHIFT_ARB_FIXED_PRIO_EN
  logic        rr_q;
`endif

  always_comb begin
    win_d = 1'b0;
`ifdef SHIFT_ARB_FIXED_PRIO_EN
    win_d = ~bus.req_valid[0];
`else
    case (bus.req_valid)
      2'b10:   win_d = 1'b1;
      2'b11:   win_d = rr_q;
      default: win_d = 1'b0;
    endcase
`endif
    // Gated by rst_n so no request is accepted while reset is held
    gnt_d = 2'b00;
    if ((state_q == S_IDLE) && rst_n && (|bus.req_valid))
      gnt_d = win_d ? 2'b10 : 2'b01;
    data_d  = win_d ? bus.req_data1  : bus.req_data0;
    shamt_d = win_d ? bus.req_shamt1 : bus.req_shamt0;
    op_d    = win_d ? bus.req_op1    : bus.req_op0;
    legal_d = (op_d == OP_SLL) || (op_d == OP_SRL) || (op_d == OP_SRA);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      win_q         <= 1'b0;
      illegal_q     <= 1'b0;
      sh_inp1_q     <= 32'd0;
      sh_inp2_q     <= 5'd0;
      sh_alusel_q   <= 4'd0;
      rsp_valid_q   <= 2'b00;
      rsp_data_q    <= 32'd0;
      rsp_illegal_q <= 1'b0;
`ifndef SHIFT_ARB_FIXED_PRIO_EN
      rr_q          <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (|gnt_d) begin
            win_q       <= win_d;
            sh_inp1_q   <= data_d;
            sh_inp2_q   <= shamt_d;
            sh_alusel_q <= legal_d ? op_d : 4'd0;
            illegal_q   <= ~legal_d;
`ifndef SHIFT_ARB_FIXED_PRIO_EN
            rr_q        <= ~win_d;
`endif
            state_q     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          rsp_data_q    <= illegal_q ? 32'd0 : bus.sh_out;
          rsp_illegal_q <= illegal_q;
          rsp_valid_q   <= win_q ? 2'b10 : 2'b01;
          state_q       <= S_RESP;
        end
        S_RESP: begin
          if (bus.rsp_ready[win_q]) begin
            rsp_valid_q   <= 2'b00;
            rsp_illegal_q <= 1'b0;
            state_q       <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.req_ready   = gnt_d;
  assign bus.sh_inp1     = sh_inp1_q;
  assign bus.sh_inp2     = sh_inp2_q;
  assign bus.sh_alusel   = sh_alusel_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_data    = rsp_data_q;
  assign bus.rsp_illegal = rsp_illegal_q;

endmodule
`default_nettype wire

// File: tb/tb_shift_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_shift_arbiter : self-checking bench for shift_arbiter           |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_shift_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;
  int   last_win = 1;
  bit   fixed_prio;

  shift_arbiter_if sif ();

  shift_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (sif.slave)
  );

  always #5 clk = ~clk;

  // Combinational barrel shifter seen by the arbiter
  always_comb begin
    case (sif.sh_alusel)
      4'd2:    sif.sh_out = sif.sh_inp1 << sif.sh_inp2;
      4'd6:    sif.sh_out = sif.sh_inp1 >> sif.sh_inp2;
      4'd7:    sif.sh_out = 32'($signed(sif.sh_inp1) >>> sif.sh_inp2);
      default: sif.sh_out = 32'hDEAD_BEEF;
    endcase
  end

  function automatic bit is_legal(input logic [3:0] op);
    return (op == 4'd2) || (op == 4'd6) || (op == 4'd7);
  endfunction

  // Reference result via multiply/divide by a power of two
  function automatic logic [31:0] ref_result(input logic [31:0] d, input int s,
                                             input logic [3:0] op);
    longint unsigned dd = 64'(d);
    longint unsigned p  = 1;
    for (int i = 0; i < s; i++) p = p * 2;
    case (op)
      4'd2: return 32'((dd * p) & 64'hFFFF_FFFF);
      4'd6: return 32'(dd / p);
      4'd7: begin
        if (d[31]) return 32'(~(((~dd) & 64'hFFFF_FFFF) / p));
        return 32'(dd / p);
      end
      default: return 32'd0;
    endcase
  endfunction

  function automatic int exp_winner(input logic [1:0] v);
    if (v == 2'b01) return 0;
    if (v == 2'b10) return 1;
    if (fixed_prio) return 0;
    return (last_win == 0) ? 1 : 0;
  endfunction

  task automatic set_req(input int p, input logic [31:0] d, input logic [4:0] s,
                         input logic [3:0] o);
    if (p == 0) begin
      sif.req_data0 = d; sif.req_shamt0 = s; sif.req_op0 = o;
    end else begin
      sif.req_data1 = d; sif.req_shamt1 = s; sif.req_op1 = o;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    sif.req_valid = 2'b11;
    sif.rsp_ready = 2'b00;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++;
    if ({sif.req_ready, sif.sh_inp1, sif.sh_inp2, sif.sh_alusel, sif.rsp_valid,
         sif.rsp_data, sif.rsp_illegal} !== 78'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got rdy=%b inp1=%h inp2=%h sel=%h rv=%b rd=%h ill=%b, want all 0",
               sif.req_ready, sif.sh_inp1, sif.sh_inp2, sif.sh_alusel, sif.rsp_valid,
               sif.rsp_data, sif.rsp_illegal);
    end
    @(negedge clk);
    sif.req_valid = 2'b00;
    rst_n = 1'b1;
    last_win = 1;
  endtask

  task automatic test_single_txn(input string name, input int p, input logic [31:0] d,
                                 input logic [4:0] s, input logic [3:0] op);
    logic [1:0]  oh;
    logic [31:0] exp_d;
    oh    = 2'b01 << p;
    exp_d = ref_result(d, int'(s), op);
    @(negedge clk);
    set_req(p, d, s, op);
    sif.req_valid = oh;
    #1;
    n_cmp++;
    if (sif.req_ready !== oh) begin
      n_err++; $display("FAIL %s_grant: got %b want %b", name, sif.req_ready, oh);
    end
    last_win = p;
    @(negedge clk);
    sif.req_valid = 2'b00;
    #1;
    n_cmp++;
    if ({sif.sh_inp1, sif.sh_inp2, sif.sh_alusel, sif.rsp_valid} !==
        {d, s, (is_legal(op) ? op : 4'd0), 2'b00}) begin
      n_err++;
      $display("FAIL %s_issue: got inp1=%h inp2=%0d sel=%0d rv=%b want inp1=%h inp2=%0d sel=%0d rv=00",
               name, sif.sh_inp1, sif.sh_inp2, sif.sh_alusel, sif.rsp_valid, d, s,
               is_legal(op) ? op : 4'd0);
    end
    @(negedge clk);
    #1;
    n_cmp++;
    if ({sif.rsp_valid, sif.rsp_data, sif.rsp_illegal} !== {oh, exp_d, ~is_legal(op)}) begin
      n_err++;
      $display("FAIL %s_resp: got rv=%b data=%h ill=%b want rv=%b data=%h ill=%b",
               name, sif.rsp_valid, sif.rsp_data, sif.rsp_illegal, oh, exp_d, ~is_legal(op));
    end
    sif.rsp_ready = oh;
    @(negedge clk);
    sif.rsp_ready = 2'b00;
    #1;
    n_cmp++;
    if ({sif.rsp_valid, sif.rsp_illegal} !== 3'b000) begin
      n_err++;
      $display("FAIL %s_release: got rv=%b ill=%b want 00/0", name, sif.rsp_valid, sif.rsp_illegal);
    end
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    set_req(1, 32'hF000_0000, 5'd4, 4'd7);
    sif.req_valid = 2'b10;
    #1;
    n_cmp++;
    if (sif.req_ready !== 2'b10) begin
      n_err++; $display("FAIL bp_grant: got %b want 10", sif.req_ready);
    end
    last_win = 1;
    @(negedge clk);
    set_req(0, 32'h1111_1111, 5'd1, 4'd2);
    sif.req_valid = 2'b11;
    sif.rsp_ready = 2'b01;
    #1;
    n_cmp++;
    if (sif.req_ready !== 2'b00) begin
      n_err++; $display("FAIL bp_issue_ready: got %b want 00", sif.req_ready);
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      #1;
      n_cmp++;
      if ({sif.rsp_valid, sif.rsp_data, sif.rsp_illegal, sif.req_ready} !==
          {2'b10, 32'hFF00_0000, 1'b0, 2'b00}) begin
        n_err++;
        $display("FAIL bp_hold[%0d]: got rv=%b data=%h ill=%b rdy=%b want rv=10 data=ff000000 ill=0 rdy=00",
                 k, sif.rsp_valid, sif.rsp_data, sif.rsp_illegal, sif.req_ready);
      end
    end
    @(negedge clk);
    sif.req_valid = 2'b00;
    sif.rsp_ready = 2'b10;
    @(negedge clk);
    sif.rsp_ready = 2'b00;
    #1;
    n_cmp++;
    if (sif.rsp_valid !== 2'b00) begin
      n_err++; $display("FAIL bp_release: got rv=%b want 00", sif.rsp_valid);
    end
  endtask

  task automatic test_alternate();
    int w;
    logic [31:0] exp_d;
    @(negedge clk);
    set_req(0, 32'h8000_0000, 5'd1, 4'd6);
    set_req(1, 32'h8000_0000, 5'd31, 4'd6);
    sif.req_valid = 2'b11;
    sif.rsp_ready = 2'b11;
    for (int k = 0; k < 6; k++) begin
      #1;
      w = exp_winner(2'b11);
      exp_d = ref_result(32'h8000_0000, (w == 1) ? 31 : 1, 4'd6);
      n_cmp++;
      if (sif.req_ready !== (2'b01 << w)) begin
        n_err++; $display("FAIL alt_grant[%0d]: got %b want %b", k, sif.req_ready, 2'b01 << w);
      end
      last_win = w;
      @(negedge clk);
      @(negedge clk);
      #1;
      n_cmp++;
      if ({sif.rsp_valid, sif.rsp_data} !== {2'b01 << w, exp_d}) begin
        n_err++;
        $display("FAIL alt_resp[%0d]: got rv=%b data=%h want rv=%b data=%h",
                 k, sif.rsp_valid, sif.rsp_data, 2'b01 << w, exp_d);
      end
      @(negedge clk);
    end
    sif.req_valid = 2'b00;
    sif.rsp_ready = 2'b00;
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    set_req(1, 32'h0000_00FF, 5'd4, 4'd2);
    sif.req_valid = 2'b10;
    #1;
    n_cmp++;
    if (sif.req_ready !== 2'b10) begin
      n_err++; $display("FAIL rstmid_grant: got %b want 10", sif.req_ready);
    end
    last_win = 1;
    @(negedge clk);
    sif.req_valid = 2'b00;
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    n_cmp++;
    if ({sif.req_ready, sif.sh_inp1, sif.sh_inp2, sif.sh_alusel, sif.rsp_valid,
         sif.rsp_data, sif.rsp_illegal} !== 78'd0) begin
      n_err++;
      $display("FAIL rstmid_outputs: got rdy=%b inp1=%h inp2=%h sel=%h rv=%b rd=%h ill=%b, want all 0",
               sif.req_ready, sif.sh_inp1, sif.sh_inp2, sif.sh_alusel, sif.rsp_valid,
               sif.rsp_data, sif.rsp_illegal);
    end
    rst_n = 1'b1;
    last_win = 1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      n_cmp++;
      if (sif.rsp_valid !== 2'b00) begin
        n_err++; $display("FAIL rstmid_no_rsp[%0d]: got rv=%b want 00", k, sif.rsp_valid);
      end
    end
    set_req(0, 32'h0000_000F, 5'd2, 4'd6);
    sif.req_valid = 2'b11;
    #1;
    n_cmp++;
    if (sif.req_ready !== 2'b01) begin
      n_err++; $display("FAIL rstmid_regrant: got %b want 01", sif.req_ready);
    end
    last_win = 0;
    @(negedge clk);
    sif.req_valid = 2'b00;
    @(negedge clk);
    #1;
    n_cmp++;
    if ({sif.rsp_valid, sif.rsp_data} !== {2'b01, 32'h0000_0003}) begin
      n_err++;
      $display("FAIL rstmid_resp: got rv=%b data=%h want rv=01 data=00000003", sif.rsp_valid, sif.rsp_data);
    end
    sif.rsp_ready = 2'b01;
    @(negedge clk);
    sif.rsp_ready = 2'b00;
  endtask

  task automatic test_random();
    logic [1:0]  v, oh;
    logic [31:0] d [2];
    logic [4:0]  s [2];
    logic [3:0]  o [2];
    logic [31:0] exp_d;
    int          w, dly;
    for (int t = 0; t < 30; t++) begin
      @(negedge clk);
      v = 2'($urandom_range(1, 3));
      for (int p = 0; p < 2; p++) begin
        d[p] = $urandom;
        s[p] = 5'($urandom_range(0, 31));
        case ($urandom_range(0, 3))
          0: o[p] = 4'd2;
          1: o[p] = 4'd6;
          2: o[p] = 4'd7;
          default: o[p] = 4'($urandom_range(0, 15));
        endcase
        set_req(p, d[p], s[p], o[p]);
      end
      sif.req_valid = v;
      #1;
      w  = exp_winner(v);
      oh = 2'b01 << w;
      exp_d = ref_result(d[w], int'(s[w]), o[w]);
      n_cmp++;
      if (sif.req_ready !== oh) begin
        n_err++; $display("FAIL rnd_grant[%0d]: v=%b got %b want %b", t, v, sif.req_ready, oh);
      end
      last_win = w;
      @(negedge clk);
      sif.req_valid = 2'b00;
      @(negedge clk);
      dly = $urandom_range(0, 3);
      for (int k = 0; k <= dly; k++) begin
        sif.rsp_ready = (k == dly) ? (oh | 2'($urandom_range(0, 3))) : (~oh & 2'($urandom_range(0, 3)));
        #1;
        n_cmp++;
        if ({sif.rsp_valid, sif.rsp_data, sif.rsp_illegal} !== {oh, exp_d, ~is_legal(o[w])}) begin
          n_err++;
          $display("FAIL rnd_resp[%0d.%0d]: got rv=%b data=%h ill=%b want rv=%b data=%h ill=%b",
                   t, k, sif.rsp_valid, sif.rsp_data, sif.rsp_illegal, oh, exp_d, ~is_legal(o[w]));
        end
        @(negedge clk);
      end
      sif.rsp_ready = 2'b00;
      #1;
      n_cmp++;
      if (sif.rsp_valid !== 2'b00) begin
        n_err++; $display("FAIL rnd_release[%0d]: got rv=%b want 00", t, sif.rsp_valid);
      end
    end
  endtask

  initial begin
`ifdef SHIFT_ARB_FIXED_PRIO_EN
    fixed_prio = 1'b1;
`else
    fixed_prio = 1'b0;
`endif
    sif.req_valid = 2'b00;
    sif.rsp_ready = 2'b00;
    set_req(0, 32'd0, 5'd0, 4'd0);
    set_req(1, 32'd0, 5'd0, 4'd0);

    test_reset();
    test_single_txn("sll31", 0, 32'h0000_0001, 5'd31, 4'd2);
    test_backpressure();
    test_alternate();
    test_single_txn("illegal", 0, 32'h1234_5678, 5'd3, 4'd5);
    test_reset_mid();
    test_single_txn("sra0", 1, 32'h8000_0001, 5'd0, 4'd7);
    test_random();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/shift_arbiter.md
Name: shift_arbiter

Overview:
- Shares the single combinational barrel shifter between two requesters: port 0 is the EX-stage ALU path, port 1 is the CSR/immediate-fixup helper.
- Accepts one shift request at a time over a valid/ready handshake and drives the shifter operands from registers.
- Captures the shifter result and returns it to the granting requester over a valid/ready response channel.
- Arbitration is round-robin by default.

Parameters:
- OP_SLL, 4'd2, shifter select code for logical left shift
- OP_SRL, 4'd6, shifter select code for logical right shift
- OP_SRA, 4'd7, shifter select code for arithmetic right shift

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  synchronous active-low reset
- req_valid  in  2  per-requester request valid; bit i = requester i
- req_ready  out  2  per-requester request accepted this cycle
- req_data0 / req_data1  in  32 each  operand to shift
- req_shamt0 / req_shamt1  in  5 each  shift amount
- req_op0 / req_op1  in  4 each  shift select code
- sh_inp1  out  32  to shifter data input
- sh_inp2  out  5  to shifter amount input
- sh_alusel  out  4  to shifter select input
- sh_out  in  32  shifter result (combinational)
- rsp_valid  out  2  result valid for requester i (one-hot or zero)
- rsp_ready  in  2  requester i consumes result
- rsp_data  out  32  result
- rsp_illegal  out  1  op was not SLL/SRL/SRA; qualified by rsp_valid

Behaviour:
- Reset (rst_n=0 at clk edge), overriding everything including mid-transaction:
  - state=IDLE; all outputs 0; rr pointer=0 (requester 0 favoured next).
  - An in-flight transaction is dropped and no response is issued.
- FSM states IDLE, ISSUE, RESP.
- IDLE:
  - req_ready = one-hot grant, combinational from req_valid and the rr pointer.
  - Round-robin: if both requesters are valid, grant the one the pointer favours. If only one is valid, grant it.
  - On grant, latch data/shamt/op and the winner index, then go to ISSUE.
  - The rr pointer moves to favour the non-winner.
  - req_ready is 0 in ISSUE and RESP.
- ISSUE (exactly 1 cycle):
  - sh_inp1, sh_inp2, sh_alusel driven from the latched registers.
  - At the clock edge, rsp_data captures sh_out.
  - If the latched op is not in {2,6,7}: rsp_data captures 32'd0, rsp_illegal=1, and sh_alusel is driven 4'd0.
  - Go to RESP.
- RESP:
  - rsp_valid[winner]=1; rsp_data and rsp_illegal are held stable.
  - When rsp_ready[winner]=1, go to IDLE; rsp_valid and rsp_illegal clear next cycle.
  - rsp_ready on the non-winner bit is ignored.
- Latency: accept edge to rsp_valid high = 2 cycles. Minimum issue interval = 3 cycles (a new request can be accepted the cycle after a response is consumed).
- sh_* outputs hold their last value in IDLE and RESP. The shifter result is sampled only in ISSUE.
- shamt=0 returns the operand unchanged. SRA sign-fills from bit 31; SRL zero-fills.
- A requester must hold its req fields stable while valid and not ready. The arbiter assumes nothing about them after grant.
- Both requesters valid continuously: grants alternate 0,1,0,1...

Optional Feature:
- SHIFT_ARB_FIXED_PRIO_EN
  - Defined: requester 0 always wins when both are valid; the rr pointer is removed.
  - Undefined: round-robin as above.

Test Plan:
- Reset, then req0 SLL data=32'h0000_0001 shamt=31 → rsp_valid=2'b01 two cycles after accept, rsp_data=32'h8000_0000, rsp_illegal=0.
- req1 SRA data=32'hF000_0000 shamt=4, rsp_ready held 0 for 5 cycles → rsp_data=32'hFF00_0000 stable, req_ready=0 throughout; then rsp_ready[1]=1 → IDLE next cycle.
- Both requesters valid continuously (SRL 32'h8000_0000 by 1 / by 31) → grants 0,1,0,1, results 32'h4000_0000 and 32'h0000_0001 alternating. With SHIFT_ARB_FIXED_PRIO_EN defined, all grants go to 0.
- req0 op=4'd5 data=32'h1234_5678 → rsp_data=0, rsp_illegal=1, sh_alusel=0 during ISSUE.
- rst_n=0 asserted during ISSUE → next cycle all outputs 0; no rsp_valid follows; next request granted to requester 0.
- shamt=0 SRA data=32'h8000_0001 → rsp_data=32'h8000_0001.
